// File: rtl/hw_checksum_engine.sv
// Streaming RFC 1071 ones'-complement checksum engine with optional IPv4 pseudo-header,
// odd-length padding, UDP zero substitution and a receive-side verify flag.
module hw_checksum_engine #(
  parameter int DATA_BYTES = 2,
  parameter int ACC_W      = 32
) (
  input  logic                    pe_clk,
  input  logic                    pe_rstn,
  input  logic                    pe_logic_clr,
  input  logic                    start,
  input  logic                    pseudo_en,
  input  logic                    udp_zero_fix,
  input  logic [31:0]             src_ip,
  input  logic [31:0]             dst_ip,
  input  logic [7:0]              protocol,
  input  logic [15:0]             l4_len,
  input  logic                    data_valid,
  input  logic [DATA_BYTES*8-1:0] data_in,
  input  logic [DATA_BYTES-1:0]   data_keep,
  input  logic                    data_last,
  output logic                    data_ready,
  output logic [15:0]             checksum_out,
  output logic                    checksum_valid,
  output logic                    checksum_ok
);

  typedef enum logic [2:0] {IDLE, PSEUDO, DATA, FOLD1, FOLD2, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_p0, ph_sum, ph_sum_nxt, beat_sum;
  logic             par_p0, beat_par, zfix;
  logic [16:0]      fold_p1;
  logic [15:0]      fold_p2;
  logic [7:0]       lane;
  logic             beat_acc;

  function automatic logic [15:0] end_around(input logic [16:0] f);
    return f[15:0] + {15'd0, f[16]};
  endfunction

  function automatic logic [15:0] zero_sub(input logic [15:0] c, input logic en);
    return (en && c == 16'h0000) ? 16'hFFFF : c;
  endfunction

  assign data_ready     = (state == DATA);
  assign checksum_valid = (state == DONE);
  assign beat_acc       = data_valid && data_ready;
  assign fold_p2        = end_around(fold_p1);

  assign ph_sum_nxt = ACC_W'(src_ip[31:16]) + ACC_W'(src_ip[15:0]) +
                      ACC_W'(dst_ip[31:16]) + ACC_W'(dst_ip[15:0]) +
                      ACC_W'(protocol)      + ACC_W'(l4_len);

  // A byte at even parity is a word's high half, so adding it pre-shifted makes the
  // trailing-byte zero pad implicit and no pending-byte register is needed.
  always_comb begin
    beat_sum = '0;
    beat_par = par_p0;
    lane     = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (data_keep[DATA_BYTES-1-i]) begin
        lane     = data_in[8*(DATA_BYTES-1-i) +: 8];
        beat_sum = beat_sum + (beat_par ? ACC_W'({8'h00, lane}) : ACC_W'({lane, 8'h00}));
        beat_par = ~beat_par;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = PSEUDO;
    end else begin
      case (state)
        PSEUDO:  state_nxt = DATA;
        DATA:    if (beat_acc && data_last) state_nxt = FOLD1;
        FOLD1:   state_nxt = FOLD2;
        FOLD2:   state_nxt = DONE;
        IDLE:    state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn)          state <= IDLE;
    else if (pe_logic_clr) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_ff @(posedge pe_clk or negedge pe_rstn) begin
    if (!pe_rstn) begin
      acc_p0       <= '0;
      par_p0       <= 1'b0;
      ph_sum       <= '0;
      zfix         <= 1'b0;
      fold_p1      <= '0;
      checksum_out <= '0;
      checksum_ok  <= 1'b0;
    end else if (pe_logic_clr) begin
      acc_p0       <= '0;
      par_p0       <= 1'b0;
      ph_sum       <= '0;
      zfix         <= 1'b0;
      fold_p1      <= '0;
      checksum_out <= '0;
      checksum_ok  <= 1'b0;
    end else if (start) begin
      acc_p0 <= '0;
      par_p0 <= 1'b0;
      ph_sum <= pseudo_en ? ph_sum_nxt : '0;
      zfix   <= udp_zero_fix;
    end else begin
      case (state)
        PSEUDO: acc_p0 <= ph_sum;
        // stage p0: per-beat accumulation
        DATA: begin
          if (beat_acc) begin
            acc_p0 <= acc_p0 + beat_sum;
            par_p0 <= data_last ? 1'b0 : beat_par;
          end
        end
        // stage p1: first fold of the upper accumulator bits
        FOLD1: fold_p1 <= 17'(acc_p0[15:0]) + 17'(acc_p0[ACC_W-1:16]);
        // stage p2: end-around carry, complement and verify
        FOLD2: begin
          checksum_out <= zero_sub(~fold_p2, zfix);
          checksum_ok  <= (fold_p2 == 16'hFFFF);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_checksum_engine.sv
// Randomized and directed bench for hw_checksum_engine against a plain-arithmetic
// RFC 1071 reference model.
module tb_hw_checksum_engine;

  localparam int DB    = 4;
  localparam int ACC_W = 32;

  typedef logic [7:0] bq_t[$];

  logic          pe_clk, pe_rstn, pe_logic_clr, start, pseudo_en, udp_zero_fix;
  logic [31:0]   src_ip, dst_ip;
  logic [7:0]    protocol;
  logic [15:0]   l4_len;
  logic          data_valid, data_last;
  logic [DB*8-1:0] data_in;
  logic [DB-1:0] data_keep;
  logic          data_ready, checksum_valid, checksum_ok;
  logic [15:0]   checksum_out;

  int n_checks = 0;
  int n_fail   = 0;

  hw_checksum_engine #(.DATA_BYTES(DB), .ACC_W(ACC_W)) dut (
    .pe_clk(pe_clk), .pe_rstn(pe_rstn), .pe_logic_clr(pe_logic_clr), .start(start),
    .pseudo_en(pseudo_en), .udp_zero_fix(udp_zero_fix), .src_ip(src_ip), .dst_ip(dst_ip),
    .protocol(protocol), .l4_len(l4_len), .data_valid(data_valid), .data_in(data_in),
    .data_keep(data_keep), .data_last(data_last), .data_ready(data_ready),
    .checksum_out(checksum_out), .checksum_valid(checksum_valid), .checksum_ok(checksum_ok)
  );

  initial pe_clk = 1'b0;
  always #5 pe_clk = ~pe_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Ones'-complement sum of big-endian 16-bit words, odd byte padded with zero.
  function automatic logic [15:0] ref_fold(input bq_t q, input logic pe, input logic [31:0] s,
                                           input logic [31:0] d, input logic [7:0] pr,
                                           input logic [15:0] len);
    longint unsigned sum;
    sum = 0;
    if (pe) sum = 64'(s[31:16]) + 64'(s[15:0]) + 64'(d[31:16]) + 64'(d[15:0]) + 64'(pr) + 64'(len);
    for (int i = 0; i < q.size(); i++)
      sum += (i % 2 == 0) ? (64'(q[i]) << 8) : 64'(q[i]);
    while (sum > 64'hFFFF) sum = (sum & 64'hFFFF) + (sum >> 16);
    return sum[15:0];
  endfunction

  task automatic start_pkt(input logic pe, input logic zf, input logic [31:0] s,
                           input logic [31:0] d, input logic [7:0] pr, input logic [15:0] len);
    start = 1'b1; pseudo_en = pe; udp_zero_fix = zf;
    src_ip = s; dst_ip = d; protocol = pr; l4_len = len;
    @(posedge pe_clk); #1;
    start = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    // pseudo-header fields must have been captured at start
    src_ip = $urandom; dst_ip = $urandom; protocol = 8'($urandom);
    l4_len = 16'($urandom); pseudo_en = 1'($urandom); udp_zero_fix = 1'($urandom);
    check_val("ready_pseudo", data_ready, 0);
    @(posedge pe_clk); #1;
    check_val("ready_data", data_ready, 1);
  endtask

  task automatic send_data(input bq_t q, input int gap_pct);
    int n, nb;
    n  = q.size();
    nb = (n == 0) ? 1 : (n + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(99) < gap_pct) begin
        data_valid = 1'b0; data_in = $urandom; data_keep = '1; data_last = 1'b1;
        repeat ($urandom_range(1, 3)) begin
          @(posedge pe_clk); #1;
        end
      end
      data_valid = 1'b1;
      data_last  = (b == nb - 1);
      data_in    = $urandom;
      data_keep  = '0;
      for (int l = 0; l < DB; l++) begin
        if (b * DB + l < n) begin
          data_in[8*(DB-1-l) +: 8] = q[b*DB+l];
          data_keep[DB-1-l] = 1'b1;
        end
      end
      @(posedge pe_clk); #1;
    end
    data_valid = 1'b0; data_last = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] exp_out, input logic exp_ok);
    check_val({tag, "_valid_n1"}, checksum_valid, 0);
    @(posedge pe_clk); #1;
    check_val({tag, "_valid_n2"}, checksum_valid, 0);
    @(posedge pe_clk); #1;
    check_val({tag, "_valid_n3"}, checksum_valid, 1);
    check_val({tag, "_out"}, checksum_out, exp_out);
    check_val({tag, "_ok"}, checksum_ok, exp_ok);
    check_val({tag, "_ready_done"}, data_ready, 0);
    data_valid = 1'b1; data_last = 1'b1; data_in = $urandom; data_keep = '1;
    repeat (2) begin
      @(posedge pe_clk); #1;
    end
    data_valid = 1'b0;
    check_val({tag, "_hold"}, checksum_out, exp_out);
  endtask

  task automatic run_case(input string tag, input bq_t q, input logic pe, input logic zf,
                          input logic [31:0] s, input logic [31:0] d, input logic [7:0] pr,
                          input logic [15:0] len, input int gap, input logic use_ref,
                          input logic [15:0] c_out, input logic c_ok);
    logic [15:0] f, e_out;
    logic        e_ok;
    if (use_ref) begin
      f     = ref_fold(q, pe, s, d, pr, len);
      e_out = (zf && ~f == 16'h0000) ? 16'hFFFF : ~f;
      e_ok  = (f == 16'hFFFF);
    end else begin
      e_out = c_out;
      e_ok  = c_ok;
    end
    start_pkt(pe, zf, s, d, pr, len);
    send_data(q, gap);
    expect_result(tag, e_out, e_ok);
  endtask

  initial begin
    bq_t q;
    logic [15:0] f;
    pe_rstn = 1'b0; pe_logic_clr = 1'b0; start = 1'b0; pseudo_en = 1'b0; udp_zero_fix = 1'b0;
    src_ip = '0; dst_ip = '0; protocol = '0; l4_len = '0;
    data_valid = 1'b0; data_in = '0; data_keep = '0; data_last = 1'b0;
    repeat (3) @(posedge pe_clk);
    #1;
    check_val("rst_ready", data_ready, 0);
    check_val("rst_valid", checksum_valid, 0);
    check_val("rst_ok", checksum_ok, 0);
    check_val("rst_out", checksum_out, 0);
    pe_rstn = 1'b1;

    // IDLE ignores data
    data_valid = 1'b1; data_last = 1'b1; data_keep = '1; data_in = $urandom;
    repeat (3) @(posedge pe_clk);
    #1;
    data_valid = 1'b0;
    check_val("idle_ready", data_ready, 0);
    check_val("idle_valid", checksum_valid, 0);

    q = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    run_case("ipv4", q, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 16'hB861, 1'b0);
    q = '{8'h01, 8'h02, 8'h03};
    run_case("odd3", q, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 16'hFBFD, 1'b0);
    q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0A, 8'h00, 8'h00, 8'hAB, 8'hCD};
    run_case("udp", q, 1'b1, 1'b0, 32'h0A000001, 32'h0A000002, 8'h11, 16'h000A, 0, 1'b0, 16'hD75D, 1'b0);
    q[6] = 8'hD7; q[7] = 8'h5D;
    run_case("udp_verify", q, 1'b1, 1'b0, 32'h0A000001, 32'h0A000002, 8'h11, 16'h000A, 30, 1'b0, 16'h0000, 1'b1);
    q = '{8'hFF, 8'hFF};
    run_case("zfix_on", q, 1'b0, 1'b1, 0, 0, 0, 0, 0, 1'b0, 16'hFFFF, 1'b1);
    run_case("zfix_off", q, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 1'b1);
    q = {};
    run_case("empty", q, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 16'hFFFF, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic pe, zf;
      logic [31:0] s, d;
      logic [7:0] pr;
      logic [15:0] len;
      q = {};
      repeat ($urandom_range(0, 40)) q.push_back(8'($urandom));
      pe = 1'($urandom); zf = 1'($urandom);
      s = $urandom; d = $urandom; pr = 8'($urandom); len = 16'($urandom);
      if (t % 3 == 2) begin
        f = ref_fold(q, pe, s, d, pr, len);
        if (q.size() % 2 == 1) q.push_back(8'h00);
        q.push_back(~f[15:8]);
        q.push_back(~f[7:0]);
      end
      run_case($sformatf("rand%0d", t), q, pe, zf, s, d, pr, len, 30, 1'b1, 16'h0, 1'b0);
    end

    // abort: pending odd byte in flight, then a beat coincident with start is dropped
    start_pkt(1'b1, 1'b1, $urandom, $urandom, 8'h06, 16'h1234);
    data_valid = 1'b1; data_last = 1'b0; data_keep = 4'b1110; data_in = $urandom;
    @(posedge pe_clk); #1;
    data_valid = 1'b1; data_last = 1'b1; data_keep = '1; data_in = $urandom;
    q = '{8'h00, 8'h01};
    start_pkt(1'b0, 1'b0, 0, 0, 0, 0);
    send_data(q, 0);
    expect_result("abort", 16'hFFFE, 1'b0);

    // clear while in FOLD1
    start_pkt(1'b0, 1'b0, 0, 0, 0, 0);
    send_data(q, 0);
    pe_logic_clr = 1'b1;
    @(posedge pe_clk); #1;
    pe_logic_clr = 1'b0;
    check_val("clr_out", checksum_out, 0);
    repeat (3) begin
      @(posedge pe_clk); #1;
      check_val("clr_valid", checksum_valid, 0);
    end
    check_val("clr_ready", data_ready, 0);

    // clear coincident with start: clear wins, FSM stays idle
    start = 1'b1; pe_logic_clr = 1'b1;
    @(posedge pe_clk); #1;
    start = 1'b0; pe_logic_clr = 1'b0;
    @(posedge pe_clk); #1;
    check_val("clr_start_ready", data_ready, 0);

    // async reset mid-DATA after a non-zero result
    run_case("pre_rst", q, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 16'hFFFE, 1'b0);
    start_pkt(1'b1, 1'b0, $urandom, $urandom, 8'h11, 16'h0040);
    data_valid = 1'b1; data_last = 1'b0; data_keep = '1; data_in = $urandom;
    @(posedge pe_clk);
    #2 pe_rstn = 1'b0;
    #1;
    check_val("arst_ready", data_ready, 0);
    check_val("arst_valid", checksum_valid, 0);
    check_val("arst_ok", checksum_ok, 0);
    check_val("arst_out", checksum_out, 0);
    data_valid = 1'b0;
    @(posedge pe_clk); #1;
    pe_rstn = 1'b1;
    @(posedge pe_clk); #1;
    q = '{8'h12, 8'h34, 8'h56};
    run_case("post_rst", q, 1'b1, 1'b0, $urandom, $urandom, 8'($urandom), 16'($urandom), 20, 1'b1, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
